// File: rtl/prbs16_checker_pkg.sv
// Shared PRBS16 definitions: polynomial taps x^16+x^14+x^13+x^11+1,
// checker state encodings and the feedback helper used by generator and checker.
package prbs16_checker_pkg;

  localparam int PRBS_LEN = 16;
  localparam int TAP_A    = 16;
  localparam int TAP_B    = 14;
  localparam int TAP_C    = 13;
  localparam int TAP_D    = 11;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_LOCKED = 2'd1,
    ST_LOST   = 2'd2
  } state_t;

  function automatic logic prbs16_fb(input logic [PRBS_LEN-1:0] sr);
    return sr[TAP_A-1] ^ sr[TAP_B-1] ^ sr[TAP_C-1] ^ sr[TAP_D-1];
  endfunction

endpackage

// File: rtl/prbs16_next.sv
// Combinational PRBS16 prediction: the bit the polynomial produces from the
// current shift-register contents.
module prbs16_next
  import prbs16_checker_pkg::*;
(
  input  logic [PRBS_LEN-1:0] sr,
  output logic                exp_bit
);

  assign exp_bit = prbs16_fb(sr);

endmodule

// File: rtl/prbs16_checker.sv
// PRBS16 receive checker: self-synchronises on the incoming stream, then
// flywheels its own prediction and counts mismatches, dropping lock on bursts.
module prbs16_checker
  import prbs16_checker_pkg::*;
#(
  parameter int LOCK_COUNT = 32,
  parameter int WINDOW     = 64,
  parameter int ERR_THRESH = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inBit,
  input  logic             inValid,
  input  logic             clrCnt,
  output logic             locked,
  output logic             errPulse,
  output logic [CNT_W-1:0] errCount
);

  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int WIN_W   = $clog2(WINDOW + 1);
  localparam int ERR_W   = $clog2(ERR_THRESH + 1);

  localparam logic [4:0]         FILL_FULL  = 5'd16;
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WINDOW - 1);
  localparam logic [ERR_W-1:0]   ERR_LIMIT  = ERR_W'(ERR_THRESH);

  state_t                state_reg, state_next;
  logic [PRBS_LEN-1:0]   sr_reg, sr_next;
  logic [4:0]            fill_reg, fill_next;
  logic [MATCH_W-1:0]    match_reg, match_next;
  logic [WIN_W-1:0]      win_cnt_reg, win_cnt_next;
  logic [ERR_W-1:0]      win_err_reg, win_err_next;
  logic [ERR_W-1:0]      err_sum;
  logic                  locked_reg, locked_next;
  logic                  pulse_reg, pulse_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic                  exp_bit;
  logic                  mismatch;

  prbs16_next u_next (
    .sr      (sr_reg),
    .exp_bit (exp_bit)
  );

  assign mismatch = inBit ^ exp_bit;

  always_comb begin
    state_next   = state_reg;
    sr_next      = sr_reg;
    fill_next    = fill_reg;
    match_next   = match_reg;
    win_cnt_next = win_cnt_reg;
    win_err_next = win_err_reg;
    locked_next  = locked_reg;
    pulse_next   = 1'b0;
    cnt_next     = cnt_reg;
    err_sum      = win_err_reg + {{(ERR_W-1){1'b0}}, mismatch};

    unique case (state_reg)
      ST_SEARCH: begin
        if (inValid) begin
          sr_next = {sr_reg[PRBS_LEN-2:0], inBit};
          if (fill_reg != FILL_FULL) begin
            fill_next = fill_reg + 5'd1;
          end else if (mismatch || (sr_reg == '0)) begin
            // an all-zero register predicts zeros forever, so never trust it
            match_next = '0;
          end else if (match_reg == MATCH_LAST) begin
            state_next   = ST_LOCKED;
            locked_next  = 1'b1;
            match_next   = '0;
            win_cnt_next = '0;
            win_err_next = '0;
          end else begin
            match_next = match_reg + 1'b1;
          end
        end
      end
      ST_LOCKED: begin
        if (inValid) begin
          // flywheel: only the local prediction enters the register
          sr_next = {sr_reg[PRBS_LEN-2:0], exp_bit};
          if (mismatch) begin
            pulse_next = 1'b1;
            if (cnt_reg != '1) cnt_next = cnt_reg + 1'b1;
          end
          if (err_sum == ERR_LIMIT) begin
            state_next   = ST_LOST;
            locked_next  = 1'b0;
            fill_next    = '0;
            match_next   = '0;
            win_cnt_next = '0;
            win_err_next = '0;
          end else if (win_cnt_reg == WIN_LAST) begin
            win_cnt_next = '0;
            win_err_next = '0;
          end else begin
            win_cnt_next = win_cnt_reg + 1'b1;
            win_err_next = err_sum;
          end
        end
      end
      ST_LOST: begin
        state_next = ST_SEARCH;
        fill_next  = '0;
        match_next = '0;
      end
      default: state_next = ST_SEARCH;
    endcase

    if (clrCnt) cnt_next = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_SEARCH;
      sr_reg      <= '0;
      fill_reg    <= '0;
      match_reg   <= '0;
      win_cnt_reg <= '0;
      win_err_reg <= '0;
      locked_reg  <= 1'b0;
      pulse_reg   <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      sr_reg      <= sr_next;
      fill_reg    <= fill_next;
      match_reg   <= match_next;
      win_cnt_reg <= win_cnt_next;
      win_err_reg <= win_err_next;
      locked_reg  <= locked_next;
      pulse_reg   <= pulse_next;
      cnt_reg     <= cnt_next;
    end
  end

  assign locked   = locked_reg;
  assign errPulse = pulse_reg;
  assign errCount = cnt_reg;

endmodule

// File: tb/tb_prbs16_checker.sv
// Directed bench for prbs16_checker: a reference PRBS16 source feeds the checker,
// a table of error-injection patterns plus hand-written lock/loss/reset sequences.
module tb_prbs16_checker;

  typedef struct {
    int w1_n;
    int w1_start;
    int w2_n;
    int exp_locked;
    int exp_cnt;
    int exp_pulses;
  } row_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       inBit = 1'b0;
  logic       inValid = 1'b0;
  logic       clrCnt = 1'b0;
  logic       locked;
  logic       errPulse;
  logic [3:0] errCount;

  int          tests = 0;
  int          failed = 0;
  int          pulses = 0;
  logic [15:0] gen_sr = 16'hACE1;

  always #5 clk = ~clk;

  prbs16_checker #(
    .LOCK_COUNT (32),
    .WINDOW     (64),
    .ERR_THRESH (8),
    .CNT_W      (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .inBit    (inBit),
    .inValid  (inValid),
    .clrCnt   (clrCnt),
    .locked   (locked),
    .errPulse (errPulse),
    .errCount (errCount)
  );

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end else begin
      $display("[TB] ok %s = %0d", name, act);
    end
  endtask

  // reference generator: Fibonacci LFSR, one new bit per valid cycle
  task automatic send(input bit flip);
    logic b;
    b = gen_sr[15] ^ gen_sr[13] ^ gen_sr[12] ^ gen_sr[10];
    gen_sr = {gen_sr[14:0], b};
    inBit = b ^ flip;
    inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    if (errPulse) pulses++;
  endtask

  task automatic send_zero();
    inBit = 1'b0;
    inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    if (errPulse) pulses++;
  endtask

  task automatic idle();
    inValid = 1'b0;
    @(posedge clk);
    #1;
    if (errPulse) pulses++;
  endtask

  task automatic do_reset(input logic [15:0] seed);
    rst = 1'b0;
    inValid = 1'b0;
    clrCnt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    gen_sr = seed;
    pulses = 0;
  endtask

  row_t rows[7];

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit f;
    rows[0] = '{0, 0, 0, 1, 0, 0};
    rows[1] = '{1, 10, 0, 1, 1, 1};
    rows[2] = '{7, 0, 7, 1, 14, 14};
    rows[3] = '{7, 50, 7, 1, 14, 14};
    rows[4] = '{8, 0, 0, 1, 8, 8};
    rows[5] = '{4, 56, 4, 1, 8, 8};
    rows[6] = '{8, 49, 0, 1, 8, 8};

    // reset state and lock latency
    do_reset(16'hACE1);
    check("reset_locked", locked, 0);
    check("reset_errPulse", errPulse, 0);
    check("reset_errCount", errCount, 0);
    repeat (47) send(1'b0);
    check("lock_after_47", locked, 0);
    send(1'b0);
    check("lock_after_48", locked, 1);
    repeat (3000) send(1'b0);
    check("clean_errCount", errCount, 0);
    check("clean_pulses", pulses, 0);
    check("clean_locked", locked, 1);

    // single flipped bit: one-cycle pulse, flywheel keeps later bits clean
    send(1'b1);
    check("single_pulse_hi", errPulse, 1);
    idle();
    check("single_pulse_idle", errPulse, 0);
    repeat (20) send(1'b0);
    check("single_errCount", errCount, 1);
    check("single_locked", locked, 1);

    // table: error patterns over two windows after lock
    for (int r = 0; r < 7; r++) begin
      do_reset(16'h1D0F + 16'(r));
      repeat (48) send(1'b0);
      pulses = 0;
      for (int p = 0; p < 128; p++) begin
        f = 1'b0;
        if (p >= rows[r].w1_start && p < rows[r].w1_start + 2 * rows[r].w1_n &&
            ((p - rows[r].w1_start) % 2) == 0) f = 1'b1;
        if (p >= 64 && p < 64 + 2 * rows[r].w2_n && (p % 2) == 0) f = 1'b1;
        send(f);
      end
      check($sformatf("row%0d_locked", r), locked, rows[r].exp_locked);
      check($sformatf("row%0d_errCount", r), errCount, rows[r].exp_cnt);
      check($sformatf("row%0d_pulses", r), pulses, rows[r].exp_pulses);
    end

    // eighth error on the window-closing bit drops lock, then relock after 48 bits
    do_reset(16'hBEEF);
    repeat (48) send(1'b0);
    repeat (49) send(1'b0);
    for (int p = 49; p < 63; p++) send(((p - 49) % 2) == 0);
    check("loss_locked_after_7", locked, 1);
    send(1'b1);
    check("loss_locked_after_8", locked, 0);
    check("loss_errCount", errCount, 8);
    idle();
    repeat (47) send(1'b0);
    check("relock_after_47", locked, 0);
    send(1'b0);
    check("relock_after_48", locked, 1);
    check("relock_errCount", errCount, 8);

    // all-zero stream never locks
    do_reset(16'h0001);
    repeat (300) send_zero();
    check("zero_locked", locked, 0);
    check("zero_errCount", errCount, 0);

    // 50% inValid: same valid-bit count to lock
    do_reset(16'h5A5A);
    for (int i = 0; i < 47; i++) begin
      send(1'b0);
      idle();
    end
    check("gap_lock_after_47", locked, 0);
    send(1'b0);
    check("gap_lock_after_48", locked, 1);

    // saturation with 4-bit counter, then clear-versus-error priority
    do_reset(16'hC0DE);
    repeat (48) send(1'b0);
    for (int p = 0; p < 256; p++) begin
      f = ((p % 64) % 10 == 5) && ((p % 64) < 50);
      send(f);
    end
    check("sat_errCount", errCount, 15);
    check("sat_locked", locked, 1);
    clrCnt = 1'b1;
    send(1'b1);
    clrCnt = 1'b0;
    check("clr_err_errCount", errCount, 0);
    check("clr_err_errPulse", errPulse, 1);
    send(1'b1);
    check("after_clr_errCount", errCount, 1);
    clrCnt = 1'b1;
    idle();
    clrCnt = 1'b0;
    check("clr_idle_errCount", errCount, 0);
    check("clr_keeps_locked", locked, 1);

    // asynchronous reset while locked with a pending pulse
    send(1'b1);
    check("prerst_errPulse", errPulse, 1);
    rst = 1'b0;
    #2;
    check("rst_async_locked", locked, 0);
    check("rst_async_errPulse", errPulse, 0);
    check("rst_async_errCount", errCount, 0);
    inValid = 1'b1;
    inBit = 1'b1;
    @(posedge clk);
    #1;
    check("rst_held_locked", locked, 0);
    check("rst_held_errCount", errCount, 0);
    inValid = 1'b0;
    rst = 1'b1;
    gen_sr = 16'h7777;
    repeat (10) send(1'b0);
    check("post_rst_locked", locked, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
